// File: rtl/prog_mem_loadable_if.sv
// Fetch-side read port and burst loader port of the loadable program memory.
// Loader handshake: a word moves on a rising edge where ld_valid_i && ld_ready_o.
interface prog_mem_loadable_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              ld_start_i;
    logic [ADDR_W-1:0] ld_base_i;
    logic [ADDR_W:0]   ld_count_i;
    logic              ld_valid_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ld_ready_o;
    logic              ld_busy_o;
    logic              ld_done_o;
    logic              ld_err_o;

    modport master (
        output rd_en_i, rd_addr_i, ld_start_i, ld_base_i, ld_count_i, ld_valid_i, ld_data_i,
        input  rd_data_o, rd_valid_o, ld_ready_o, ld_busy_o, ld_done_o, ld_err_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, ld_start_i, ld_base_i, ld_count_i, ld_valid_i, ld_data_i,
        output rd_data_o, rd_valid_o, ld_ready_o, ld_busy_o, ld_done_o, ld_err_o
    );
endinterface

// File: rtl/prog_mem_loadable.sv
// Program memory with a 1-cycle registered fetch port and a burst loader.
// Never-written words read as DEFAULT_WORD via a per-word written flag.
module prog_mem_loadable #(
    parameter int                 DATA_W       = 8,
    parameter int                 ADDR_W       = 8,
    parameter logic [DATA_W-1:0]  DEFAULT_WORD = 8'hFF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    prog_mem_loadable_if.slave  bus,
    output logic [1:0]          dbg_state
);
    localparam int DEPTH = 2 ** ADDR_W;
    // One spare bit so base+count never wraps, even for count > DEPTH.
    localparam int SUM_W = ADDR_W + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ld_err;
    logic              wr_en;
    logic [SUM_W-1:0]  end_addr;
    logic              start_ok;

    assign end_addr = SUM_W'(bus.ld_base_i) + SUM_W'(bus.ld_count_i);
    assign start_ok = (bus.ld_count_i != '0) && (end_addr <= SUM_W'(DEPTH));
    assign wr_en    = (state == ST_LOAD) && bus.ld_valid_i;

    // Word storage carries no reset; the written flags make stale contents invisible.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[ptr] <= bus.ld_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            written <= '0;
        end else if (wr_en) begin
            written[ptr] <= 1'b1;
        end
    end

    // Read-first: mem/written update on the same edge, so a colliding read sees the old word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                rd_data <= written[bus.rd_addr_i] ? mem[bus.rd_addr_i] : DEFAULT_WORD;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            remaining <= '0;
            ld_err    <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.ld_start_i) begin
                        if (start_ok) begin
                            ptr       <= bus.ld_base_i;
                            remaining <= bus.ld_count_i;
                            state     <= ST_LOAD;
                        end else begin
                            ld_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid_i) begin
                        ptr       <= ptr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W + 1)'(1);
                        if (remaining == (ADDR_W + 1)'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_data_o  = rd_data;
    assign bus.rd_valid_o = rd_valid;
    assign bus.ld_ready_o = (state == ST_LOAD);
    assign bus.ld_busy_o  = (state != ST_IDLE);
    assign bus.ld_done_o  = (state == ST_DONE);
    assign bus.ld_err_o   = ld_err;
    assign dbg_state      = state;
endmodule
